seq_tx: RTL and testbench
=========================

Name: seq_tx

Overview:
Serial pattern transmitter. The transmit-side counterpart of the team's serial sequence detectors. It emits a fixed bit pattern MSB-first on a one-bit line, repeats it a programmed number of times, and inserts idle gap cycles between frames. It sits upstream of a detector, either as a link source or as a self-test stimulus generator.

Parameters:
PAT_W, 7, pattern length in bits (>=2)
PATTERN, 7'b1010101, pattern transmitted MSB (bit PAT_W-1) first
GAP, 2, idle cycles between consecutive frames (0 = back-to-back)
CNT_W, 8, width of repetition count

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  request transmission; sampled only in IDLE
count  input  CNT_W  frames to send, latched on accepted start; 0 = continuous until stop
stop  input  1  request end of continuous/multi-frame run; sampled while busy
out  output  1  serial data bit
out_valid  output  1  out carries a pattern bit this cycle
frame_start  output  1  high during the cycle carrying the first (MSB) bit of each frame
busy  output  1  transmission in progress (SEND or GAP)
done  output  1  one-cycle pulse when a run ends

Behaviour:
- One clock; rst is asynchronous and active-low. rst low forces state IDLE immediately, without a clock edge, with all outputs 0 and all internal counters and stop_pending cleared.
- All outputs are registered and change only on rising clk edges, except under reset.
- States:
  - IDLE: out=0, out_valid=0, busy=0, frame_start=0.
  - SEND: out=PATTERN[idx], out_valid=1, busy=1.
  - GAP: out=0, out_valid=0, busy=1.
- IDLE, start=1 at an edge:
  - Latch count into rep_left; continuous mode if count==0.
  - Set idx=PAT_W-1, clear stop_pending, enter SEND.
  - First bit is visible the cycle after the start edge (latency 1).
- SEND:
  - idx decrements each edge.
  - frame_start=1 only while idx==PAT_W-1.
  - At the edge ending idx==0, the end-of-frame decision applies:
    - End run if (not continuous and rep_left==1) or stop_pending, or stop=1 that same cycle. Go to IDLE and pulse done.
    - Otherwise decrement rep_left (not in continuous mode). If GAP>0, enter GAP with gcnt=GAP-1. If GAP==0, reload idx=PAT_W-1 and stay in SEND, so the next MSB follows immediately.
- GAP:
  - gcnt decrements each edge.
  - At the edge ending gcnt==0: enter SEND with idx=PAT_W-1.
  - stop=1 in any GAP cycle (or stop_pending already set): next edge goes to IDLE and pulses done.
- stop while in SEND sets stop_pending. The frame in flight always completes; frames are never truncated.
- stop in IDLE is ignored. If start and stop are both high in IDLE, start is accepted and stop is ignored.
- start while busy is ignored. start during the done cycle is accepted, since the state is already IDLE.
- done:
  - High for exactly one cycle, the cycle after the final transmitted bit or after the stop-terminated gap cycle.
  - busy=0 in that cycle.
  - Exactly one done per run.
- Continuous mode: rep_left is not decremented; only stop or reset ends the run.
- count changes after start is accepted have no effect on the current run.
- Busy duration for N frames: N*PAT_W + (N-1)*GAP cycles.

Test Plan:
1. Reset, then start with count=1 (defaults) -> out = 1,0,1,0,1,0,1 on 7 consecutive cycles starting the cycle after start. out_valid=1 and busy=1 for those 7 cycles; frame_start only on the first; done=1 on cycle 8 with busy=0.
2. count=3, GAP=2 -> three 7-bit frames, each followed by 2 cycles with out_valid=0 except after the last. busy high for 25 cycles, frame_start pulses 3 times, a single done.
3. count=0 (continuous), stop pulsed on the 4th bit of frame 2 -> frame 2 finishes all 7 bits, done in the following cycle, no frame 3. Second case: stop during a GAP cycle -> IDLE and done on the next cycle, no further bits.
4. rst driven low asynchronously mid-frame at bit 4 -> out, out_valid, busy, frame_start drop to 0 before the next edge, no done. After rst release the block stays idle until start.
5. start pulsed while busy -> ignored, frame count unchanged. start asserted during the done cycle -> new frame MSB appears on the next cycle.
6. GAP=0, count=2 -> 14 contiguous valid bits 1010101 1010101 with frame_start on bits 1 and 8; done on cycle 15.

Source files
------------

// File: rtl/seq_tx.sv
// seq_tx: serial pattern transmitter.
// Sends PATTERN MSB-first on a one-bit line, repeats it a programmed number of
// frames (or continuously until stop), and puts GAP idle cycles between frames.
// Every output is a register fed from the next-state decode, so outputs move
// only on clock edges; reset clears them at once.
module seq_tx #(
    parameter int                PAT_W   = 7,
    parameter logic [PAT_W-1:0]  PATTERN = 7'b1010101,
    parameter int                GAP     = 2,
    parameter int                CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             stop,
    output logic             out,
    output logic             out_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W  = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int GCNT_W = (GAP > 1) ? $clog2(GAP) : 1;

    // idx counts down from the MSB position; gcnt counts down the idle gap
    localparam logic [IDX_W-1:0]  IDX_TOP  = IDX_W'(PAT_W - 1);
    localparam logic [GCNT_W-1:0] GAP_LOAD = GCNT_W'((GAP > 0) ? (GAP - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [GCNT_W-1:0]  gcnt, gcnt_n;
    logic [CNT_W-1:0]   rep_left, rep_n;
    logic               cont, cont_n;
    logic               stop_pend, pend_n;
    logic               done_n;
    logic               out_n, vld_n, fs_n, busy_n;

    // State register and registered outputs, all cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            gcnt        <= '0;
            rep_left    <= '0;
            cont        <= 1'b0;
            stop_pend   <= 1'b0;
            out         <= 1'b0;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            gcnt        <= gcnt_n;
            rep_left    <= rep_n;
            cont        <= cont_n;
            stop_pend   <= pend_n;
            out         <= out_n;
            out_valid   <= vld_n;
            frame_start <= fs_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

    // Next-state decode: frame sequencing, repetition count and stop handling
    always_comb begin
        state_n = state;
        idx_n   = idx;
        gcnt_n  = gcnt;
        rep_n   = rep_left;
        cont_n  = cont;
        pend_n  = stop_pend;
        done_n  = 1'b0;
        case (state)
            S_IDLE: begin
                // stop is meaningless here; start wins even if both are high
                if (start) begin
                    rep_n   = count;
                    cont_n  = (count == '0);
                    idx_n   = IDX_TOP;
                    pend_n  = 1'b0;
                    state_n = S_SEND;
                end
            end
            S_SEND: begin
                // a stop mid-frame is remembered; the frame always completes
                if (stop) pend_n = 1'b1;
                if (idx == '0) begin
                    if ((!cont && rep_left == CNT_W'(1)) || stop_pend || stop) begin
                        state_n = S_IDLE;
                        pend_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        if (!cont) rep_n = rep_left - CNT_W'(1);
                        if (GAP > 0) begin
                            state_n = S_GAP;
                            gcnt_n  = GAP_LOAD;
                        end else begin
                            idx_n = IDX_TOP;
                        end
                    end
                end else begin
                    idx_n = idx - IDX_W'(1);
                end
            end
            S_GAP: begin
                // no frame is in flight, so a stop ends the run right away
                if (stop || stop_pend) begin
                    state_n = S_IDLE;
                    pend_n  = 1'b0;
                    done_n  = 1'b1;
                end else if (gcnt == '0) begin
                    state_n = S_SEND;
                    idx_n   = IDX_TOP;
                end else begin
                    gcnt_n = gcnt - GCNT_W'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the outputs can be registered
    always_comb begin
        vld_n  = (state_n == S_SEND);
        out_n  = vld_n & PATTERN[idx_n];
        fs_n   = vld_n && (idx_n == IDX_TOP);
        busy_n = (state_n != S_IDLE);
    end

endmodule

// File: tb/tb_seq_tx.sv
// Testbench for seq_tx: per-scenario tasks checked against a frame-level model.
module tb_seq_tx;

    localparam int              PAT_W   = 7;
    localparam logic [6:0]      PATTERN = 7'b1010101;
    localparam int              GAP     = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] count;
    logic       stop;

    logic out, out_valid, frame_start, busy, done;
    logic out0, out_valid0, frame_start0, busy0, done0;

    logic       sel;
    logic [4:0] obs;
    logic [4:0] exp_q[$];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    seq_tx u_dut (
        .clk(clk), .rst(rst), .start(start), .count(count), .stop(stop),
        .out(out), .out_valid(out_valid), .frame_start(frame_start),
        .busy(busy), .done(done)
    );

    seq_tx #(.GAP(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .count(count), .stop(stop),
        .out(out0), .out_valid(out_valid0), .frame_start(frame_start0),
        .busy(busy0), .done(done0)
    );

    // observed vector {out, out_valid, frame_start, busy, done}
    always_comb obs = sel ? {out0, out_valid0, frame_start0, busy0, done0}
                          : {out, out_valid, frame_start, busy, done};

    // Model: append a run's per-cycle outputs, frame by frame.
    // n = frame count (0 = continuous), stop_at = absolute cycle of a stop pulse.
    task automatic build_expect(input int n, input int gap, input int stop_at,
                                output int done_t);
        int  f;
        bit  stopped;
        bit  ended;
        f = 0; stopped = 0; ended = 0;
        while (!ended) begin
            for (int b = 0; b < PAT_W; b++) begin
                exp_q.push_back({PATTERN[PAT_W-1-b], 1'b1, (b == 0), 1'b1, 1'b0});
                if (exp_q.size() == stop_at) stopped = 1;
            end
            f++;
            if ((n != 0 && f == n) || stopped) begin
                ended = 1;
            end else begin
                for (int g = 0; g < gap && !ended; g++) begin
                    exp_q.push_back(5'b00010);
                    if (exp_q.size() == stop_at) ended = 1;
                end
            end
        end
        exp_q.push_back(5'b00001);
        done_t = exp_q.size();
    endtask

    // Drive a run starting now and compare every cycle of exp_q.
    task automatic run_exp(input string name, input int cnt, input int stop_at,
                           input bit junk, input int restart_t, input int restart_cnt);
        int sz;
        sz = exp_q.size();
        @(posedge clk); #1;
        start = 1'b1;
        count = 8'(cnt);
        stop  = (stop_at == 0);
        for (int t = 1; t <= sz; t++) begin
            @(posedge clk); #1;
            start = (t == restart_t) ||
                    (junk && t <= sz - 2 && $urandom_range(0, 2) == 0);
            count = (t == restart_t) ? 8'(restart_cnt) : 8'($urandom_range(0, 255));
            stop  = (t == stop_at);
            @(negedge clk);
            n_chk++;
            if (obs !== exp_q[t-1])
                $display("FAIL %s cycle %0d: got %b want %b (out,vld,fs,busy,done)",
                         name, t, obs, exp_q[t-1]);
            else
                n_pass++;
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic test_reset;
        sel = 0; rst = 1'b0; start = 1'b0; stop = 1'b0; count = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (obs !== 5'b00000) $display("FAIL reset_hold: got %b want 00000", obs);
        else n_pass++;
        @(posedge clk); #1 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            stop = (i == 1);
            @(negedge clk);
            n_chk++;
            if (obs !== 5'b00000) $display("FAIL idle_after_reset %0d: got %b want 00000", i, obs);
            else n_pass++;
        end
        stop = 1'b0;
    endtask

    task automatic test_single;
        int d;
        sel = 0; exp_q.delete();
        build_expect(1, GAP, -1, d);
        exp_q.push_back(5'b00000);
        run_exp("single", 1, -1, 0, -1, 0);
    endtask

    task automatic test_multi;
        int d;
        sel = 0; exp_q.delete();
        build_expect(3, GAP, -1, d);
        exp_q.push_back(5'b00000);
        run_exp("multi3", 3, -1, 0, -1, 0);
    endtask

    task automatic test_cont_stop;
        int d;
        sel = 0; exp_q.delete();
        build_expect(0, GAP, 13, d);
        exp_q.push_back(5'b00000);
        run_exp("cont_stop_frame", 0, 13, 0, -1, 0);
        exp_q.delete();
        build_expect(0, GAP, 8, d);
        exp_q.push_back(5'b00000);
        run_exp("cont_stop_gap", 0, 8, 0, -1, 0);
    endtask

    task automatic test_start_stop_idle;
        int d;
        sel = 0; exp_q.delete();
        build_expect(1, GAP, 0, d);
        exp_q.push_back(5'b00000);
        run_exp("start_with_stop", 1, 0, 0, -1, 0);
    endtask

    task automatic test_async_reset;
        int d;
        sel = 0; exp_q.delete();
        build_expect(1, GAP, -1, d);
        @(posedge clk); #1;
        start = 1'b1; count = 8'd1;
        for (int t = 1; t <= 4; t++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            n_chk++;
            if (obs !== exp_q[t-1])
                $display("FAIL async_pre cycle %0d: got %b want %b", t, obs, exp_q[t-1]);
            else n_pass++;
        end
        #2 rst = 1'b0;
        #1;
        n_chk++;
        if (obs !== 5'b00000) $display("FAIL async_drop: got %b want 00000", obs);
        else n_pass++;
        repeat (2) begin
            @(negedge clk);
            n_chk++;
            if (obs !== 5'b00000) $display("FAIL async_hold: got %b want 00000", obs);
            else n_pass++;
        end
        @(posedge clk); #1 rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            n_chk++;
            if (obs !== 5'b00000) $display("FAIL post_reset_idle: got %b want 00000", obs);
            else n_pass++;
        end
    endtask

    task automatic test_start_busy;
        int d;
        sel = 0; exp_q.delete();
        build_expect(2, GAP, -1, d);
        exp_q.push_back(5'b00000);
        run_exp("start_while_busy", 2, -1, 1, -1, 0);
    endtask

    task automatic test_start_on_done;
        int d1, d2;
        sel = 0; exp_q.delete();
        build_expect(1, GAP, -1, d1);
        build_expect(2, GAP, -1, d2);
        exp_q.push_back(5'b00000);
        run_exp("start_on_done", 1, -1, 0, d1, 2);
    endtask

    task automatic test_random;
        int d, cnt, sa;
        bit junk;
        sel = 0;
        for (int i = 0; i < 8; i++) begin
            cnt  = $urandom_range(0, 3);
            junk = $urandom_range(0, 1);
            if (cnt == 0) sa = $urandom_range(1, 25);
            else sa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 30)) : -1;
            exp_q.delete();
            build_expect(cnt, GAP, sa, d);
            exp_q.push_back(5'b00000);
            run_exp($sformatf("random%0d_cnt%0d_stop%0d", i, cnt, sa), cnt, sa, junk, -1, 0);
        end
    endtask

    task automatic test_gap0;
        int d;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        sel = 1; exp_q.delete();
        build_expect(2, 0, -1, d);
        exp_q.push_back(5'b00000);
        run_exp("gap0_cnt2", 2, -1, 0, -1, 0);
        exp_q.delete();
        build_expect(0, 0, 10, d);
        exp_q.push_back(5'b00000);
        run_exp("gap0_cont_stop", 0, 10, 0, -1, 0);
        sel = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_cont_stop();
        test_start_stop_idle();
        test_async_reset();
        test_start_busy();
        test_start_on_done();
        test_random();
        test_gap0();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
